// File: rtl/kick_timer_if.sv
// kick_timer_if -- control/status bundle for kick_timer.
//   en, go, reload : per-channel enable, restart, auto-reload mode
//   lim_wr/lim_sel/lim_data : limit register write port
//   count  : packed per-channel counts, channel n at [n*WIDTH +: WIDTH]
//   done   : one-cycle terminal pulse per channel
//   paused : channel is idle in PAUSE
// master drives controls and reads status; slave is the timer side.
interface kick_timer_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
);
  localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0]       en;
  logic [CHANNELS-1:0]       go;
  logic [CHANNELS-1:0]       reload;
  logic                      lim_wr;
  logic [SELW-1:0]           lim_sel;
  logic [WIDTH-1:0]          lim_data;
  logic [CHANNELS*WIDTH-1:0] count;
  logic [CHANNELS-1:0]       done;
  logic [CHANNELS-1:0]       paused;

  modport master (
    output en, go, reload, lim_wr, lim_sel, lim_data,
    input  count, done, paused
  );

  modport slave (
    input  en, go, reload, lim_wr, lim_sel, lim_data,
    output count, done, paused
  );
endinterface

// File: rtl/kick_timer.sv
// kick_timer -- bank of CHANNELS independent up-counters with per-channel
// programmable limit, one-shot or auto-reload mode and a done pulse.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset (all channels PAUSE, count 0,
//           limit MAXCOUNT)
//   bus   : kick_timer_if.slave (en, go, reload, limit write port in;
//           count, done, paused out -- all outputs are registers)
module kick_timer #(
  parameter int               WIDTH    = 16,
  parameter int               CHANNELS = 4,
  parameter logic [WIDTH-1:0] MAXCOUNT = 16'd43840
) (
  input logic         clk,
  input logic         reset,
  kick_timer_if.slave bus
);

  typedef enum logic {
    ST_PAUSE = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  state_e              state_q [CHANNELS];
  state_e              state_d [CHANNELS];
  logic [WIDTH-1:0]    cnt_q   [CHANNELS];
  logic [WIDTH-1:0]    cnt_d   [CHANNELS];
  logic [WIDTH-1:0]    lim_q   [CHANNELS];
  logic [WIDTH-1:0]    lim_d   [CHANNELS];
  logic [CHANNELS-1:0] done_q;
  logic [CHANNELS-1:0] done_d;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        state_q[i] <= ST_PAUSE;
        cnt_q[i]   <= '0;
        lim_q[i]   <= MAXCOUNT;
      end
      done_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    done_d = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      lim_d[i]   = lim_q[i];

      // go has top priority; being outside the terminal branch it also
      // keeps done low on the restart edge.
      if (bus.go[i]) begin
        state_d[i] = ST_COUNT;
        cnt_d[i]   = '0;
      end else if (state_q[i] == ST_COUNT) begin
        // >= rather than == so a limit lowered below the running count
        // terminates instead of letting the counter run on and wrap.
        if (cnt_q[i] >= lim_q[i]) begin
          done_d[i] = 1'b1;
          if (bus.reload[i]) begin
            cnt_d[i] = '0;
          end else begin
            state_d[i] = ST_PAUSE;
          end
        end else if (bus.en[i]) begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end

      // Out-of-range selects never match any channel index.
      if (bus.lim_wr && (32'(bus.lim_sel) == i)) begin
        lim_d[i] = bus.lim_data;
      end
    end
  end

  // Output logic (register-only)
  always_comb begin
    bus.count  = '0;
    bus.paused = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      bus.count[i*WIDTH +: WIDTH] = cnt_q[i];
      bus.paused[i]               = (state_q[i] == ST_PAUSE);
    end
    bus.done = done_q;
  end

endmodule

// File: tb/tb_kick_timer.sv
module tb_kick_timer;
  localparam int W  = 16;
  localparam int CH = 2;
  localparam int VW = CH*W + 2*CH;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  kick_timer_if #(.WIDTH(W), .CHANNELS(CH)) bus();

  kick_timer #(.WIDTH(W), .CHANNELS(CH), .MAXCOUNT(16'd43840)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: per channel a running flag, an integer count and limit.
  int m_cnt [CH];
  int m_lim [CH];
  bit m_run [CH];
  bit m_done[CH];

  function automatic logic [VW-1:0] exp_all();
    logic [CH*W-1:0] c;
    logic [CH-1:0]   d, p;
    for (int ch = 0; ch < CH; ch++) begin
      c[ch*W +: W] = W'(m_cnt[ch]);
      d[ch]        = m_done[ch];
      p[ch]        = !m_run[ch];
    end
    return {c, d, p};
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < CH; ch++) begin
      m_cnt[ch] = 0; m_lim[ch] = 43840; m_run[ch] = 0; m_done[ch] = 0;
    end
  endtask

  // Apply the timer rules for one clock edge using the inputs as they stand.
  task automatic model_step();
    for (int ch = 0; ch < CH; ch++) begin
      bit nd = 0;
      if (bus.go[ch]) begin
        m_run[ch] = 1; m_cnt[ch] = 0;
      end else if (m_run[ch]) begin
        if (m_cnt[ch] >= m_lim[ch]) begin
          nd = 1;
          if (bus.reload[ch]) m_cnt[ch] = 0;
          else                m_run[ch] = 0;
        end else if (bus.en[ch]) begin
          m_cnt[ch] = (m_cnt[ch] + 1) % (1 << W);
        end
      end
      if (bus.lim_wr && int'(bus.lim_sel) == ch) m_lim[ch] = int'(bus.lim_data);
      m_done[ch] = nd;
    end
  endtask

  task automatic tick();
    if (!reset) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.en = '0; bus.go = '0; bus.reload = '0;
    bus.lim_wr = 1'b0; bus.lim_sel = '0; bus.lim_data = '0;
  endtask

  task automatic wr_lim(input int ch, input int val);
    bus.lim_wr = 1'b1; bus.lim_sel = 1'(ch); bus.lim_data = W'(val);
    tick();
    bus.lim_wr = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    #2 reset = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if ({bus.count, bus.done, bus.paused} !== {32'h0, 2'b00, 2'b11}) begin
      n_err++;
      $display("FAIL reset_async: got %h want %h", {bus.count, bus.done, bus.paused}, {32'h0, 2'b00, 2'b11});
    end
    bus.go = 2'b11;
    tick();
    tick();
    reset  = 1'b0;
    bus.go = 2'b00;
    bus.en = 2'b11;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_cmp++;
      if ({bus.count, bus.done, bus.paused} !== {32'h0, 2'b00, 2'b11}) begin
        n_err++;
        $display("FAIL reset_idle[%0d]: got %h want %h", k, {bus.count, bus.done, bus.paused}, {32'h0, 2'b00, 2'b11});
      end
    end
    bus.en = 2'b00;
  endtask

  task automatic test_oneshot();
    wr_lim(0, 5);
    bus.reload[0] = 1'b0;
    bus.go[0] = 1'b1;
    tick();
    bus.go[0] = 1'b0;
    bus.en[0] = 1'b1;
    n_cmp++;
    if ({bus.count[15:0], bus.done[0], bus.paused[0]} !== {16'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL oneshot_start: got %h want %h", {bus.count[15:0], bus.done[0], bus.paused[0]}, {16'd0, 1'b0, 1'b0});
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_cmp++;
      if ({bus.count[15:0], bus.done[0], bus.paused[0]} !== {16'(k), 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL oneshot_count[%0d]: got %h want %h", k, {bus.count[15:0], bus.done[0], bus.paused[0]}, {16'(k), 1'b0, 1'b0});
      end
    end
    tick();
    n_cmp++;
    if ({bus.count[15:0], bus.done[0], bus.paused[0]} !== {16'd5, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL oneshot_done: got %h want %h", {bus.count[15:0], bus.done[0], bus.paused[0]}, {16'd5, 1'b1, 1'b1});
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if ({bus.count[15:0], bus.done[0], bus.paused[0]} !== {16'd5, 1'b0, 1'b1}) begin
        n_err++;
        $display("FAIL oneshot_hold[%0d]: got %h want %h", k, {bus.count[15:0], bus.done[0], bus.paused[0]}, {16'd5, 1'b0, 1'b1});
      end
      n_cmp++;
      if ({bus.count, bus.done, bus.paused} !== exp_all()) begin
        n_err++;
        $display("FAIL oneshot_model: got %h want %h", {bus.count, bus.done, bus.paused}, exp_all());
      end
    end
    bus.en[0] = 1'b0;
  endtask

  task automatic test_autoreload();
    wr_lim(1, 3);
    bus.reload[1] = 1'b1;
    bus.go[1] = 1'b1;
    tick();
    bus.go[1] = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      bit want;
      bus.en[1] = (k != 13 && k != 14);
      tick();
      want = (k == 4 || k == 8 || k == 12 || k == 18 || k == 22);
      n_cmp++;
      if (bus.done[1] !== want) begin
        n_err++;
        $display("FAIL reload_done[%0d]: got %b want %b", k, bus.done[1], want);
      end
      n_cmp++;
      if ({bus.count, bus.done, bus.paused} !== exp_all()) begin
        n_err++;
        $display("FAIL reload_model[%0d]: got %h want %h", k, {bus.count, bus.done, bus.paused}, exp_all());
      end
    end
  endtask

  task automatic test_lower_limit();
    wr_lim(0, 100);
    bus.reload[0] = 1'b0;
    bus.go[0] = 1'b1;
    tick();
    bus.go[0] = 1'b0;
    bus.en[0] = 1'b1;
    repeat (10) tick();
    bus.en[0] = 1'b0;
    wr_lim(0, 4);
    n_cmp++;
    if ({bus.count[15:0], bus.done[0], bus.paused[0]} !== {16'd10, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL lower_write: got %h want %h", {bus.count[15:0], bus.done[0], bus.paused[0]}, {16'd10, 1'b0, 1'b0});
    end
    tick();
    n_cmp++;
    if ({bus.count[15:0], bus.done[0], bus.paused[0]} !== {16'd10, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL lower_term: got %h want %h", {bus.count[15:0], bus.done[0], bus.paused[0]}, {16'd10, 1'b1, 1'b1});
    end
    n_cmp++;
    if ({bus.count, bus.done, bus.paused} !== exp_all()) begin
      n_err++;
      $display("FAIL lower_model: got %h want %h", {bus.count, bus.done, bus.paused}, exp_all());
    end
  endtask

  task automatic test_go_at_terminal();
    wr_lim(0, 2);
    bus.go[0] = 1'b1;
    tick();
    bus.go[0] = 1'b0;
    bus.en[0] = 1'b1;
    tick();
    tick();
    bus.go[0] = 1'b1;
    tick();
    bus.go[0] = 1'b0;
    n_cmp++;
    if ({bus.count[15:0], bus.done[0], bus.paused[0]} !== {16'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL goterm_restart: got %h want %h", {bus.count[15:0], bus.done[0], bus.paused[0]}, {16'd0, 1'b0, 1'b0});
    end
    tick();
    n_cmp++;
    if ({bus.count[15:0], bus.done[0], bus.paused[0]} !== {16'd1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL goterm_next: got %h want %h", {bus.count[15:0], bus.done[0], bus.paused[0]}, {16'd1, 1'b0, 1'b0});
    end
    n_cmp++;
    if ({bus.count, bus.done, bus.paused} !== exp_all()) begin
      n_err++;
      $display("FAIL goterm_model: got %h want %h", {bus.count, bus.done, bus.paused}, exp_all());
    end
    bus.en[0] = 1'b0;
  endtask

  task automatic test_limit_zero();
    wr_lim(0, 0);
    bus.reload[0] = 1'b0;
    bus.go[0] = 1'b1;
    tick();
    bus.go[0] = 1'b0;
    tick();
    n_cmp++;
    if ({bus.count[15:0], bus.done[0], bus.paused[0]} !== {16'd0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL zero_oneshot: got %h want %h", {bus.count[15:0], bus.done[0], bus.paused[0]}, {16'd0, 1'b1, 1'b1});
    end
    wr_lim(1, 0);
    bus.reload[1] = 1'b1;
    bus.en[1] = 1'b1;
    bus.go[1] = 1'b1;
    tick();
    bus.go[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if ({bus.count[31:16], bus.done[1], bus.paused[1]} !== {16'd0, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL zero_reload[%0d]: got %h want %h", k, {bus.count[31:16], bus.done[1], bus.paused[1]}, {16'd0, 1'b1, 1'b0});
      end
    end
  endtask

  task automatic test_reset_midcount();
    int guard = 0;
    wr_lim(1, 3);
    bus.reload[1] = 1'b1;
    bus.en[1] = 1'b1;
    bus.go[1] = 1'b1;
    tick();
    bus.go[1] = 1'b0;
    while (m_cnt[1] != 2 && guard < 10) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (bus.count[31:16] !== 16'd2) begin
      n_err++;
      $display("FAIL midreset_reach: got %0d want 2", bus.count[31:16]);
    end
    #2 reset = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if ({bus.count, bus.done, bus.paused} !== {32'h0, 2'b00, 2'b11}) begin
      n_err++;
      $display("FAIL midreset_abort: got %h want %h", {bus.count, bus.done, bus.paused}, {32'h0, 2'b00, 2'b11});
    end
    bus.go = 2'b11;
    tick();
    reset = 1'b0;
    bus.go = 2'b00;
    bus.en = 2'b11;
    repeat (3) begin
      tick();
      n_cmp++;
      if ({bus.count, bus.done, bus.paused} !== {32'h0, 2'b00, 2'b11}) begin
        n_err++;
        $display("FAIL midreset_idle: got %h want %h", {bus.count, bus.done, bus.paused}, {32'h0, 2'b00, 2'b11});
      end
    end
    // Limit must be back at 43840: 50 enabled cycles count straight up.
    bus.go[1] = 1'b1;
    tick();
    bus.go[1] = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      n_cmp++;
      if ({bus.count[31:16], bus.done[1]} !== {16'(k), 1'b0}) begin
        n_err++;
        $display("FAIL midreset_limit[%0d]: got %h want %h", k, {bus.count[31:16], bus.done[1]}, {16'(k), 1'b0});
      end
    end
    bus.en = 2'b00;
  endtask

  task automatic test_random();
    idle();
    for (int k = 0; k < 600; k++) begin
      for (int ch = 0; ch < CH; ch++) begin
        bus.en[ch] = ($urandom_range(0, 3) != 0);
        bus.go[ch] = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 31) == 0) bus.reload[ch] = ~bus.reload[ch];
      end
      bus.lim_wr   = ($urandom_range(0, 7) == 0);
      bus.lim_sel  = 1'($urandom_range(0, 1));
      bus.lim_data = W'($urandom_range(0, 7));
      tick();
      n_cmp++;
      if ({bus.count, bus.done, bus.paused} !== exp_all()) begin
        n_err++;
        $display("FAIL random[%0d]: got %h want %h", k, {bus.count, bus.done, bus.paused}, exp_all());
      end
    end
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_oneshot();
    test_autoreload();
    test_lower_limit();
    test_go_at_terminal();
    test_limit_zero();
    test_reset_midcount();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
